fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Downstream drain stage for `fifo_sync`. It pops 16-bit words from the FIFO and presents them on a valid/ready stream, absorbing the FIFO's one-cycle read latency in a 2-entry output buffer. It also frames the stream into fixed-length bursts with a last flag. It sits between `fifo_sync` and any stream consumer, such as a serializer or DMA writer.

## Interface
- `DATA_W`, default 16: word width; must match `fifo_sync`.
- `BURST_LEN`, default 4: words per burst; legal range 2..256.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  `empty` from `fifo_sync`.
- `fifo_data`  in  DATA_W  `data_out` from `fifo_sync`.
- `fifo_read`  out  1  `read` strobe to `fifo_sync`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_W  output word (buffer head).
- `m_last`  out  1  final word of the current burst.
- `word_total`  out  32  handshake count; present only with `FIFO_RD_STREAM_STATS_EN`.

## Operation
- The FIFO contract is fixed. A `read` sampled with `empty` low yields the word on `data_out` in the following cycle.
- State:
  - `occ` (0..2): buffer occupancy.
  - `inflight` (1 bit): a read was issued last cycle.
  - `beat` (0..BURST_LEN-1): position within the current burst.
- `pop = m_valid && m_ready`.
- `fifo_read = !fifo_empty && (occ + inflight - pop) < 2`. This is combinational and is evaluated at 2-bit+ width with no underflow.
- `inflight` is set when `fifo_read` is high, and cleared otherwise.
- When `inflight` is high, `fifo_data` is written to the buffer tail in that cycle, unconditionally.
- `m_valid = (occ != 0)`. `m_data` is the head entry.
- Buffer order is strict FIFO. A capture and a pop may occur in the same cycle; occupancy is then unchanged and the head advances.
- `m_last = m_valid && beat == BURST_LEN-1`.
- `beat` increments on `pop` and wraps to 0 after `BURST_LEN-1`.
- Credit rule guarantees `occ + inflight <= 2`. Overflow is impossible, and no data is ever dropped or duplicated.
- If `fifo_empty` rises while `inflight` is high, the in-flight word is still captured and delivered.
- Reset (including mid-burst):
  - `occ`, `inflight` and `beat` go to 0.
  - Buffer contents and `m_data` clear to 0.
  - An in-flight word is discarded. `fifo_sync` is reset on the same `rst`.

## Timing
- Reset values: `fifo_read`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `word_total`=0.
- Latency:
  - `fifo_read` high in cycle N gives `m_valid` high in cycle N+2.
  - This holds if the buffer was empty; otherwise the word queues behind the buffered data.
- Throughput: one word per cycle sustained while `m_ready`=1 and the FIFO is non-empty.
- Backpressure:
  - With `m_ready`=0, at most 2 reads are issued, then `fifo_read` stays low.
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- `m_valid` never deasserts without a handshake, except on reset.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined:
  - Adds the `word_total` port, a 32-bit counter incremented on each `pop`.
  - It saturates at 0xFFFFFFFF and clears on `rst`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `fifo_stream_pkg` holds:
  - `DATA_W_DEF` = 16.
  - The `word_t` typedef.
  - The 2-bit `occ_t` typedef.
  - The `STATS_W` = 32 constant.
- Sub-module `stream_skid2`: the 2-entry buffer.
  - Inputs: push, pop, data.
  - Outputs: head, occupancy.
- `fifo_rd_stream` contains the credit logic, the `inflight` flag, the `beat` counter and the optional stats counter.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `fifo_empty`=0.
  - `fifo_read`=0, `m_valid`=0, `m_data`=0x0000 and `m_last`=0 throughout.
- **Streaming:** FIFO preloaded with 0x0010..0x0015, `m_ready`=1.
  - `fifo_read` is high for 6 consecutive cycles.
  - `m_data` shows 0x0010..0x0015 on 6 consecutive cycles, starting 2 cycles after the first read.
  - `m_last` is high on 0x0013 only.
- **Backpressure:** same preload, `m_ready`=0 for 10 cycles, then 1.
  - Exactly 2 reads are issued and `m_data` holds 0x0010.
  - After release, all 6 words arrive in order, with no loss or duplication.
- **Empty during flight:** one word 0x00AB; `fifo_empty` rises the cycle after the read.
  - 0x00AB is delivered once, with no further `fifo_read`.
- **Mid-burst reset:** reset asserted after 2 handshakes, then 4 new words 0x0020..0x0023.
  - `m_valid` drops in the cycle after `rst` is sampled.
  - `m_last` is asserted on 0x0023.
- **Stats (`FIFO_RD_STREAM_STATS_EN`):** 10 handshakes.
  - `word_total`=10.
  - Asserting `rst` returns `word_total` to 0.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the fifo_sync drain / stream stage.
package fifo_stream_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int STATS_W    = 32;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [1:0]            occ_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the drain stage.
// master = drain stage, slave = FIFO/consumer environment.
interface fifo_rd_stream_if
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_read, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_read, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry strict-FIFO buffer that absorbs the one-cycle FIFO read latency.
module stream_skid2
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output occ_t              occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Upstream credit keeps push away from a full buffer, so no overflow guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_sync onto a valid/ready stream framed into BURST_LEN-word bursts.
// Optional word_total counter enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  fifo_rd_stream_if.master bus
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STATS_W-1:0] word_total
`endif
);

  localparam int BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

  occ_t              occ;
  logic              inflight;
  logic              pop;
  logic [2:0]        credit;
  logic [BEAT_W-1:0] beat;
  logic              beat_end;

  assign pop = bus.m_valid && bus.m_ready;

  // Words held or on their way, after this cycle's pop; pop implies occ >= 1.
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign bus.fifo_read = !rst && !bus.fifo_empty && (credit < 3'd2);
  assign bus.m_valid   = (occ != 2'd0);
  assign beat_end      = (beat == BEAT_W'(BURST_LEN - 1));
  assign bus.m_last    = bus.m_valid && beat_end;

  stream_skid2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .push(inflight),
    .pop (pop),
    .data(bus.fifo_data),
    .head(bus.m_data),
    .occ (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= bus.fifo_read;
      if (pop) begin
        beat <= beat_end ? '0 : beat + 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_total <= '0;
    end else if (pop) begin
      word_total <= sat_inc(word_total);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural fifo_sync model.
module tb_fifo_rd_stream;
  import fifo_stream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold_nonempty = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  word_t fifo_mem [64];
  int    fifo_wr = 0;
  int    fifo_rd = 0;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STATS_W-1:0] word_total;
`endif

  fifo_rd_stream_if #(.DATA_W(16)) bus ();

  fifo_rd_stream #(
    .DATA_W   (16),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .word_total(word_total)
`endif
  );

  always #5 clk = ~clk;

  // fifo_sync model: word appears on data_out the cycle after a read
  assign bus.fifo_empty = hold_nonempty ? 1'b0 : (fifo_rd == fifo_wr);

  always @(posedge clk) begin
    if (rst) begin
      fifo_rd       <= fifo_wr;
      bus.fifo_data <= '0;
    end else if (bus.fifo_read && !bus.fifo_empty) begin
      bus.fifo_data <= fifo_mem[fifo_rd[5:0]];
      fifo_rd       <= fifo_rd + 1;
    end
  end

  // expected waveforms for a 6-word stream with m_ready=1, window 0 = first read
  int    st_rd [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int    st_vl [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  int    st_lt [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  word_t st_dt [9] = '{16'h0000, 16'h0000, 16'h0010, 16'h0011, 16'h0012,
                       16'h0013, 16'h0014, 16'h0015, 16'h0000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input word_t first, input int n);
    for (int k = 0; k < n; k++) begin
      fifo_mem[fifo_wr[5:0]] = first + 16'(k);
      fifo_wr = fifo_wr + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int nreads;
  int nvalid;
  int got;

  initial begin
    bus.m_ready = 1'b0;

    // reset with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rst_read%0d", i), 32'(bus.fifo_read), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(bus.m_valid), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(bus.m_data), 32'h0000);
      chk($sformatf("rst_last%0d", i), 32'(bus.m_last), 32'd0);
    end

    // streaming
    hold_nonempty = 1'b0;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    load(16'h0010, 6);
    #1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("st_read%0d", i), 32'(bus.fifo_read), 32'(st_rd[i]));
      chk($sformatf("st_valid%0d", i), 32'(bus.m_valid), 32'(st_vl[i]));
      if (st_vl[i] != 0) begin
        chk($sformatf("st_data%0d", i), 32'(bus.m_data), 32'(st_dt[i]));
        chk($sformatf("st_last%0d", i), 32'(bus.m_last), 32'(st_lt[i]));
      end
      tick();
    end

    // backpressure
    bus.m_ready = 1'b0;
    do_reset();
    load(16'h0010, 6);
    #1;
    nreads = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fifo_read) nreads++;
      tick();
    end
    chk("bp_reads", 32'(nreads), 32'd2);
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_hold_data", 32'(bus.m_data), 32'h0010);
    bus.m_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && got < 6; i++) begin
      if (bus.m_valid && bus.m_ready) begin
        chk($sformatf("bp_word%0d", got), 32'(bus.m_data), 32'h0010 + 32'(got));
        chk($sformatf("bp_last%0d", got), 32'(bus.m_last), (got == 3) ? 32'd1 : 32'd0);
        got++;
      end
      tick();
    end
    chk("bp_count", 32'(got), 32'd6);
    tick();
    chk("bp_drained", 32'(bus.m_valid), 32'd0);

    // FIFO goes empty while the only word is in flight
    do_reset();
    load(16'h00AB, 1);
    #1;
    chk("ef_read0", 32'(bus.fifo_read), 32'd1);
    tick();
    chk("ef_empty1", 32'(bus.fifo_empty), 32'd1);
    nreads = 0;
    nvalid = 0;
    for (int i = 1; i < 8; i++) begin
      if (bus.fifo_read) nreads++;
      if (bus.m_valid) begin
        nvalid++;
        chk($sformatf("ef_data%0d", i), 32'(bus.m_data), 32'h00AB);
      end
      tick();
    end
    chk("ef_extra_reads", 32'(nreads), 32'd0);
    chk("ef_deliveries", 32'(nvalid), 32'd1);

    // reset in the middle of a burst
    do_reset();
    load(16'h0030, 6);
    #1;
    for (int i = 0; i < 4; i++) tick();
    chk("mb_pre_valid", 32'(bus.m_valid), 32'd1);
    chk("mb_pre_data", 32'(bus.m_data), 32'h0032);
    rst = 1'b1;
    tick();
    chk("mb_valid_drop", 32'(bus.m_valid), 32'd0);
    chk("mb_data_clr", 32'(bus.m_data), 32'h0000);
    chk("mb_read_off", 32'(bus.fifo_read), 32'd0);
    tick();
    rst = 1'b0;
    load(16'h0020, 4);
    #1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("mb_valid%0d", i), 32'(bus.m_valid), (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
      if (i >= 2 && i <= 5) begin
        chk($sformatf("mb_data%0d", i), 32'(bus.m_data), 32'h0020 + 32'(i - 2));
        chk($sformatf("mb_last%0d", i), 32'(bus.m_last), (i == 5) ? 32'd1 : 32'd0);
      end
      tick();
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    do_reset();
    chk("stats_reset0", word_total, 32'd0);
    load(16'h0040, 10);
    for (int i = 0; i < 14; i++) tick();
    chk("stats_total", word_total, 32'd10);
    rst = 1'b1;
    tick();
    chk("stats_clear", word_total, 32'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
